// File: rtl/oam_dma.sv
// oam_dma: sprite OAM DMA engine; snoops CPU writes to $4014 and copies a 256-byte page to $2004.
// Optional build macro OAM_DMA_ALIGN_EN inserts an ALIGN cycle when HALT falls on an odd cycle.
`default_nettype none

module oam_dma (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_R_nW,
  input  logic [7:0]  bus_data_in,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_out,
  output logic        dma_R_nW,
  output logic        dma_done
);

  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_PORT = 16'h2004;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic        active_q, active_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        rnw_q, rnw_d;
  logic        done_q, done_d;
  logic        align_req;

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q;

  // Free-running cycle parity; an odd HALT cycle needs one extra ALIGN cycle.
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) parity_q <= 1'b0;
    else      parity_q <= ~parity_q;
  end

  assign align_req = parity_q;
`else
  assign align_req = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    cnt_d    = cnt_q;
    rdy_d    = rdy_q;
    active_d = active_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rnw_d    = rnw_q;
    done_d   = 1'b0;

    // Outputs are registered, so each branch loads the values for the state being entered.
    case (state_q)
      S_IDLE: begin
        if (cpu_addr == DMA_REG && !cpu_R_nW) begin
          page_d   = cpu_data_out;
          cnt_d    = 8'h00;
          state_d  = S_HALT;
          rdy_d    = 1'b0;
          active_d = 1'b1;
          rnw_d    = 1'b1;
        end
      end
      S_HALT: begin
        if (align_req) begin
          state_d = S_ALIGN;
        end else begin
          state_d = S_READ;
          addr_d  = {page_q, cnt_q};
        end
      end
      S_ALIGN: begin
        state_d = S_READ;
        addr_d  = {page_q, cnt_q};
      end
      S_READ: begin
        data_d  = bus_data_in;
        state_d = S_WRITE;
        addr_d  = OAM_PORT;
        rnw_d   = 1'b0;
      end
      S_WRITE: begin
        rnw_d = 1'b1;
        if (cnt_q == 8'hFF) begin
          state_d  = S_IDLE;
          rdy_d    = 1'b1;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          // Counter wraps inside the page; the page never increments.
          cnt_d   = cnt_q + 8'd1;
          state_d = S_READ;
          addr_d  = {page_q, cnt_q + 8'd1};
        end
      end
      default: begin
        state_d  = S_IDLE;
        rdy_d    = 1'b1;
        active_d = 1'b0;
        rnw_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      page_q   <= 8'h00;
      cnt_q    <= 8'h00;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      addr_q   <= 16'h0000;
      data_q   <= 8'h00;
      rnw_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rnw_q    <= rnw_d;
      done_q   <= done_d;
    end
  end

  assign rdy          = rdy_q;
  assign dma_active   = active_q;
  assign dma_addr     = addr_q;
  assign dma_data_out = data_q;
  assign dma_R_nW     = rnw_q;
  assign dma_done     = done_q;

endmodule

`default_nettype wire

// File: doc/oam_dma.md
# oam_dma

Sprite OAM DMA engine sitting on the CPU's external bus, between the CPU core and the system bus mux. It snoops CPU writes to $4014, stalls the CPU through an active-high ready line, and copies 256 bytes from CPU page $XX00–$XXFF to the PPU OAM data port $2004 as alternating read/write bus cycles. While `dma_active` is high, the bus mux takes address, data and R_nW from this block instead of from the CPU.

## Interface
- `DMA_REG`, 16'h4014: CPU address that triggers a transfer.
- `OAM_PORT`, 16'h2004: destination address for every write cycle.
- `clk_ph1`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  16  CPU address bus.
- `cpu_data_out`  in  8  CPU output data bus.
- `cpu_R_nW`  in  1  CPU read/not-write.
- `bus_data_in`  in  8  system bus read data; valid at the end of a DMA read cycle.
- `rdy`  out  1  CPU ready; low stalls the CPU.
- `dma_active`  out  1  bus mux select; high means this block owns the bus.
- `dma_addr`  out  16  DMA address.
- `dma_data_out`  out  8  DMA write data.
- `dma_R_nW`  out  1  DMA read/not-write.
- `dma_done`  out  1  one-cycle pulse after the last write.

## Operation
- **States:** IDLE, HALT, ALIGN, READ, WRITE. All outputs are registered.
- **Trigger:** in IDLE, a sampled `cpu_addr == DMA_REG` with `cpu_R_nW == 0` does three things:
  - latches `page <= cpu_data_out`;
  - clears `cnt` (8 bits) to 0;
  - moves to HALT.
- **HALT (1 cycle):** `rdy = 0`, `dma_active = 1`, `dma_R_nW = 1`, `dma_addr` holds its last value. Exit goes to ALIGN if alignment is required (see Configuration), otherwise to READ.
- **ALIGN (1 cycle):** same outputs as HALT; then moves to READ.
- **READ:**
  - `dma_addr = {page, cnt}`, `dma_R_nW = 1`.
  - At the end of the cycle, latch `bus_data_in` into `dma_data_out`, then move to WRITE.
- **WRITE:**
  - `dma_addr = OAM_PORT`, `dma_R_nW = 0`, `dma_data_out` holds the latched byte.
  - At the end of the cycle: if `cnt == 8'hFF`, go to IDLE and pulse `dma_done`; otherwise `cnt <= cnt + 1` and go to READ.
- **Counter:** `cnt` is strictly 8-bit with no carry into `page`, so the source never crosses the page boundary.
- **Parity:** a 1-bit `parity` register toggles every cycle from reset (reset value 0). A cycle is "odd" when `parity == 1`.
- **Retrigger:** writes to `DMA_REG` while not in IDLE are ignored; `page` is not reloaded.
- **Other CPU traffic:** CPU reads of `DMA_REG` and writes to other addresses have no effect.
- **Reset:** reset asserted at any point, including mid-transfer, forces IDLE immediately. The partially written OAM contents are not restored.
- **Reset values:**
  - `rdy = 1`, `dma_active = 0`, `dma_addr = 16'h0000`, `dma_data_out = 8'h00`;
  - `dma_R_nW = 1`, `dma_done = 0`;
  - `page = 0`, `cnt = 0`, `parity = 0`.

## Timing
- **Trigger sampling:** the trigger is sampled at rising edge E0. From E0 onward:
  - `rdy` is low and `dma_active` is high starting in the cycle after E0;
  - both remain so until the edge that leaves WRITE with `cnt == FF`.
- **Stall length:** 513 cycles without ALIGN, 514 with ALIGN. This is 1 HALT + optional ALIGN + 256 × (READ + WRITE).
- **Release:** in the cycle after the final WRITE:
  - `rdy = 1`, `dma_active = 0`, `dma_done = 1` for exactly one cycle;
  - `dma_R_nW = 1`.
- **Read latency:** READ→WRITE data latency is 1 cycle; `bus_data_in` is sampled only on the edge ending a READ.
- **Trigger on the final edge:** a trigger coinciding with the final WRITE edge is ignored, because the FSM is not yet in IDLE when it is sampled.

## Configuration
- **Macro:** `OAM_DMA_ALIGN_EN`.
- **Defined:** HALT goes to ALIGN when `parity == 1` during the HALT cycle, so the stall is 513 or 514 cycles depending on parity.
- **Undefined:** ALIGN is never entered, the parity register is not instantiated, and every stall is exactly 513 cycles.

## Test plan
- **Basic copy:** load page $02 with $00..$FF and write $02 to $4014. Expect:
  - 256 writes to $2004 carrying data $00..$FF in order;
  - reads from $0200..$02FF;
  - `dma_done` pulses once.
- **Stall length:**
  - trigger on an even-parity HALT: `rdy` is low for 513 cycles in both builds;
  - trigger on an odd-parity HALT: 514 cycles with `OAM_DMA_ALIGN_EN`, 513 without.
- **Page boundary:** write $FF to $4014. The last read address is $FFFF, and the next `dma_addr` is $2004, never $0000 or $0100.
- **Retrigger ignored:** write $05 to $4014 mid-transfer of page $03. All reads stay in $03xx and the stall length is unchanged.
- **Reset mid-transfer:** assert `rst` low after 100 write cycles. Expect:
  - `rdy = 1`, `dma_active = 0`, `dma_R_nW = 1` immediately, without waiting for a clock edge;
  - a fresh trigger after reset release runs a full 256-byte transfer.
- **Non-trigger traffic:** a CPU read of $4014 and a CPU write to $4015 leave `rdy` high and `dma_active` low.
